// File: rtl/loop_replay_buf.sv
// Loop replay buffer: passes fetched bundles through to decode, captures a
// loop body (up to 64 instructions) once the loop table hits, and replays
// it from the buffer while fetch is stalled until unrolling is finished.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | pass-through, waiting for a loop-table hit
// CAPTURE | pass-through, appending valid slots of each bundle
// REPLAY  | buffer is the instruction source, iterating the loop body
module loop_replay_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst_in,
  input  logic [63:0] pc_in,
  input  logic [3:0]  inst_valid_in,
  input  logic        loop_strt_in,
  input  logic        stll_ftch_in,
  input  logic        fnsh_unrll_in,
  input  logic        mis_pred_in,
  input  logic        dcd_rdy_in,
  output logic [63:0] inst_out,
  output logic [63:0] pc_out,
  output logic [3:0]  inst_valid_out,
  output logic        rplying_out,
  output logic        buf_ovfl_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    REPLAY  = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [5:0]  rd_ptr_q, rd_ptr_d;
  logic [6:0]  iter_q, iter_d;
  logic        pend_q, pend_d;
  logic [63:0] inst_q, inst_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  vld_q, vld_d;
  logic        ovfl_q, ovfl_d;

  // each entry is {inst, pc}; contents are deliberately not reset
  logic [31:0] mem_q [64];

  logic        wr_en;
  logic [5:0]  wr_base;
  logic [2:0]  k;
  logic [6:0]  rem;
  logic [2:0]  m;
  logic [6:0]  rd_end;
  logic [3:0]  rd_mask;
  logic [63:0] rd_inst;
  logic [63:0] rd_pc;

  // number of valid slots in the incoming bundle
  always_comb begin
    k = '0;
    for (int j = 0; j < 4; j++) begin
      k = k + {2'b00, inst_valid_in[j]};
    end
  end

  // replay bundle: up to four entries, never crossing the loop end
  always_comb begin
    rem     = cnt_q - {1'b0, rd_ptr_q};
    m       = (rem >= 7'd4) ? 3'd4 : rem[2:0];
    rd_end  = {1'b0, rd_ptr_q} + {4'b0000, m};
    rd_mask = '0;
    rd_inst = '0;
    rd_pc   = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < m) begin
        rd_mask[3-j]            = 1'b1;
        rd_inst[63-16*j -: 16]  = mem_q[rd_ptr_q + 6'(j)][31:16];
        rd_pc[63-16*j -: 16]    = mem_q[rd_ptr_q + 6'(j)][15:0];
      end
    end
  end

  // next-state, pointer and output-register logic; mispredict wins over all
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    iter_d   = iter_q;
    pend_d   = pend_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    vld_d    = vld_q;
    ovfl_d   = 1'b0;
    wr_en    = 1'b0;
    wr_base  = '0;

    if (mis_pred_in) begin
      state_d  = IDLE;
      vld_d    = '0;
      cnt_d    = '0;
      rd_ptr_d = '0;
      iter_d   = '0;
      pend_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dcd_rdy_in) begin
            inst_d = inst_in;
            pc_d   = pc_in;
            vld_d  = inst_valid_in;
            if (loop_strt_in) begin
              wr_en   = 1'b1;
              wr_base = '0;
              cnt_d   = {4'b0000, k};
              iter_d  = '0;
              state_d = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (dcd_rdy_in) begin
            inst_d = inst_in;
            pc_d   = pc_in;
            vld_d  = inst_valid_in;
            if (stll_ftch_in && (cnt_q != 7'd0)) begin
              rd_ptr_d = '0;
              state_d  = REPLAY;
            end else if ((cnt_q + {4'b0000, k}) > 7'd64) begin
              ovfl_d  = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              wr_en   = 1'b1;
              wr_base = cnt_q[5:0];
              cnt_d   = cnt_q + {4'b0000, k};
            end
          end
        end
        REPLAY: begin
          // the finish request is remembered even while decode stalls
          if (fnsh_unrll_in) pend_d = 1'b1;
          if (dcd_rdy_in) begin
            inst_d = rd_inst;
            pc_d   = rd_pc;
            vld_d  = rd_mask;
            if (rd_end >= cnt_q) begin
              rd_ptr_d = '0;
              iter_d   = (iter_q == 7'd127) ? iter_q : iter_q + 7'd1;
              if (pend_q || fnsh_unrll_in) begin
                pend_d  = 1'b0;
                state_d = IDLE;
              end
            end else begin
              rd_ptr_d = rd_end[5:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      iter_q   <= '0;
      pend_q   <= 1'b0;
      inst_q   <= '0;
      pc_q     <= '0;
      vld_q    <= '0;
      ovfl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      iter_q   <= iter_d;
      pend_q   <= pend_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      ovfl_q   <= ovfl_d;
    end
  end

  // capture the valid slots of the current bundle in slot order
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) < k) begin
          mem_q[wr_base + 6'(j)] <= {inst_in[63-16*j -: 16], pc_in[63-16*j -: 16]};
        end
      end
    end
  end

  assign inst_out       = inst_q;
  assign pc_out         = pc_q;
  assign inst_valid_out = vld_q;
  assign rplying_out    = (state_q == REPLAY);
  assign buf_ovfl_out   = ovfl_q;

endmodule
